sram_pingpong_sched: RTL and testbench



---
 rtl/sram_sched_pkg.sv | 16 +
 rtl/sram_pingpong_sched_if.sv | 38 +++
 rtl/sram_bank_slot.sv | 56 +++++
 rtl/sram_pingpong_sched.sv | 153 +++++++++++++++
 tb/tb_sram_pingpong_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_sched_pkg.sv
// Shared types for the ping-pong SRAM frame-buffer scheduler: bank
// lifecycle states and the bank-index width.
package sram_sched_pkg;

  localparam int BANK_IDX_W = 1;

  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/sram_pingpong_sched_if.sv
// Handshake bundle between the bank scheduler (slave) and the capture
// writer / USB reader / debug side (master).
interface sram_pingpong_sched_if
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DROP_W = 8
);

  logic                  abort;
  logic                  wr_start;
  logic                  wr_grant;
  logic [BANK_IDX_W-1:0] wr_bank;
  logic                  wr_busy;
  logic                  wr_done;
  logic [ADDR_W-1:0]     wr_len;
  logic                  rd_avail;
  logic [BANK_IDX_W-1:0] rd_bank;
  logic [ADDR_W-1:0]     rd_len;
  logic                  rd_start;
  logic                  rd_done;
  logic [DROP_W-1:0]     drop_cnt;
  logic [3:0]            bank_state;
  logic                  proto_err;

  modport slave (
    input  abort, wr_start, wr_done, wr_len, rd_start, rd_done,
    output wr_grant, wr_bank, wr_busy, rd_avail, rd_bank, rd_len,
           drop_cnt, bank_state, proto_err
  );

  modport master (
    output abort, wr_start, wr_done, wr_len, rd_start, rd_done,
    input  wr_grant, wr_bank, wr_busy, rd_avail, rd_bank, rd_len,
           drop_cnt, bank_state, proto_err
  );

endinterface

// File: rtl/sram_bank_slot.sv
// One SRAM bank's lifecycle state and stored frame length; exposes both the
// current and next state so the scheduler can register its outputs.
module sram_bank_slot
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              set_fill_i,
  input  logic              set_full_i,
  input  logic              set_drain_i,
  input  logic              set_free_i,
  input  logic [ADDR_W-1:0] len_i,
  output bank_state_e       state_o,
  output bank_state_e       state_next_o,
  output logic [ADDR_W-1:0] len_next_o
);

  bank_state_e       state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // A freed bank that is re-granted in the same cycle must end up FILLING.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (clear_i) begin
      state_d = FREE;
    end else if (set_fill_i) begin
      state_d = FILLING;
    end else if (set_full_i) begin
      state_d = FULL;
      len_d   = len_i;
    end else if (set_drain_i) begin
      state_d = DRAINING;
    end else if (set_free_i) begin
      state_d = FREE;
    end
  end

  assign state_o      = state_q;
  assign state_next_o = state_d;
  assign len_next_o   = len_d;

endmodule

// File: rtl/sram_pingpong_sched.sv
// Ping-pong SRAM bank scheduler: grants banks to the capture writer, hands
// completed frames to the USB reader oldest-first, and overwrites on overflow.
module sram_pingpong_sched
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DROP_W = 8
) (
  input logic                  clk_fast,
  input logic                  rst,
  sram_pingpong_sched_if.slave bus
);

  bank_state_e       stQ   [2];
  bank_state_e       stD   [2];
  bank_state_e       effSt [2];
  logic [ADDR_W-1:0] lenD  [2];

  logic [1:0] setFill, setFull, setDrain, setFree;
  logic       busy, draining, startOk, doneOk, rdStartOk, rdDoneOk;
  logic       protoHit, dropHit;
  bank_idx_t  fillBank, drainBank, pick;

  logic              wr_grant_q, wr_grant_d;
  bank_idx_t         wr_bank_q, wr_bank_d;
  logic              wr_busy_q, wr_busy_d;
  logic              rd_avail_q, rd_avail_d;
  bank_idx_t         rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_len_q, rd_len_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [3:0]        bank_state_q, bank_state_d;
  logic              proto_err_q, proto_err_d;
  bank_idx_t         older_q, older_d;
  bank_idx_t         last_wr_q, last_wr_d;

  always_comb begin
    busy      = (stQ[0] == FILLING)  || (stQ[1] == FILLING);
    draining  = (stQ[0] == DRAINING) || (stQ[1] == DRAINING);
    fillBank  = bank_idx_t'(stQ[1] == FILLING);
    drainBank = bank_idx_t'(stQ[1] == DRAINING);
    startOk   = !bus.abort && bus.wr_start && !busy;
    doneOk    = !bus.abort && bus.wr_done && busy;
    rdStartOk = !bus.abort && bus.rd_start && rd_avail_q;
    rdDoneOk  = !bus.abort && bus.rd_done && draining;
    protoHit  = (bus.wr_start && busy) || (bus.wr_done && !busy) ||
                (bus.rd_start && !rd_avail_q) || (bus.rd_done && !draining);
  end

  // Reader moves are applied before arbitration, so a bank freed this cycle is
  // grantable and a bank the reader takes this cycle is never overwritten.
  always_comb begin
    effSt = stQ;
    if (rdDoneOk)  effSt[drainBank] = FREE;
    if (rdStartOk) effSt[rd_bank_q] = DRAINING;
    if (effSt[0] == FREE && effSt[1] == FREE)      pick = ~last_wr_q;
    else if (effSt[0] == FREE)                     pick = 1'b0;
    else if (effSt[1] == FREE)                     pick = 1'b1;
    else if (effSt[0] == FULL && effSt[1] == FULL) pick = older_q;
    else                                           pick = bank_idx_t'(effSt[1] == FULL);
    dropHit = startOk && (effSt[pick] == FULL);
  end

  always_comb begin
    setFill  = '0;
    setFull  = '0;
    setDrain = '0;
    setFree  = '0;
    if (startOk) setFill[pick] = 1'b1;
    if (doneOk) begin
      if (bus.wr_len != '0) setFull[fillBank] = 1'b1;
      else                  setFree[fillBank] = 1'b1;
    end
    if (rdStartOk) setDrain[rd_bank_q] = 1'b1;
    if (rdDoneOk)  setFree[drainBank]  = 1'b1;
  end

  for (genvar b = 0; b < 2; b++) begin : gSlot
    sram_bank_slot #(.ADDR_W(ADDR_W)) uSlot (
      .clk          (clk_fast),
      .rst          (rst),
      .clear_i      (bus.abort),
      .set_fill_i   (setFill[b]),
      .set_full_i   (setFull[b]),
      .set_drain_i  (setDrain[b]),
      .set_free_i   (setFree[b]),
      .len_i        (bus.wr_len),
      .state_o      (stQ[b]),
      .state_next_o (stD[b]),
      .len_next_o   (lenD[b])
    );
  end

  // A bank completing now is younger than whatever the other bank holds.
  always_comb begin
    wr_grant_d   = startOk;
    wr_bank_d    = startOk ? pick : wr_bank_q;
    last_wr_d    = startOk ? pick : last_wr_q;
    wr_busy_d    = (stD[0] == FILLING) || (stD[1] == FILLING);
    older_d      = (doneOk && bus.wr_len != '0) ? ~fillBank : older_q;
    drop_cnt_d   = drop_cnt_q;
    if (dropHit && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    proto_err_d  = bus.abort ? 1'b0 : (proto_err_q | protoHit);
    bank_state_d = {stD[1], stD[0]};
    rd_avail_d   = (stD[0] != DRAINING) && (stD[1] != DRAINING) &&
                   ((stD[0] == FULL) || (stD[1] == FULL));
    rd_bank_d    = rd_bank_q;
    rd_len_d     = rd_len_q;
    if (rd_avail_d) begin
      rd_bank_d = (stD[0] == FULL && stD[1] == FULL) ? older_d
                                                     : bank_idx_t'(stD[1] == FULL);
      rd_len_d  = lenD[rd_bank_d];
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      wr_grant_q   <= 1'b0;
      wr_bank_q    <= '0;
      wr_busy_q    <= 1'b0;
      rd_avail_q   <= 1'b0;
      rd_bank_q    <= '0;
      rd_len_q     <= '0;
      drop_cnt_q   <= '0;
      bank_state_q <= '0;
      proto_err_q  <= 1'b0;
      older_q      <= '0;
      last_wr_q    <= 1'b1;
    end else begin
      wr_grant_q   <= wr_grant_d;
      wr_bank_q    <= wr_bank_d;
      wr_busy_q    <= wr_busy_d;
      rd_avail_q   <= rd_avail_d;
      rd_bank_q    <= rd_bank_d;
      rd_len_q     <= rd_len_d;
      drop_cnt_q   <= drop_cnt_d;
      bank_state_q <= bank_state_d;
      proto_err_q  <= proto_err_d;
      older_q      <= older_d;
      last_wr_q    <= last_wr_d;
    end
  end

  assign bus.wr_grant   = wr_grant_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.wr_busy    = wr_busy_q;
  assign bus.rd_avail   = rd_avail_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.rd_len     = rd_len_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.bank_state = bank_state_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_sram_pingpong_sched.sv
// Bench for the ping-pong bank scheduler: directed scenarios plus random
// traffic, compared against a queue-based frame-ordering model.
module tb_sram_pingpong_sched;

  localparam int AW = 20;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  sram_pingpong_sched_if #(.ADDR_W(AW), .DROP_W(DW)) bus ();

  sram_pingpong_sched #(.ADDR_W(AW), .DROP_W(DW)) dut (
    .clk_fast (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Model: bank states as 0..3, completed frames kept in arrival order.
  int            mState [2];
  logic [AW-1:0] mLen   [2];
  int            fullQ  [$];
  int            mLastWr, mWrBank, mRdBank, mDrop;
  bit            mGrant, mBusy, mAvail, mErr;
  logic [AW-1:0] mRdLen;

  task automatic modelReset();
    mState[0] = 0; mState[1] = 0;
    mLen[0] = '0; mLen[1] = '0;
    fullQ.delete();
    mLastWr = 1; mWrBank = 0; mRdBank = 0; mDrop = 0;
    mGrant = 0; mBusy = 0; mAvail = 0; mErr = 0; mRdLen = '0;
  endtask

  task automatic modelStep(input bit ab, input bit ws, input bit wd,
                           input logic [AW-1:0] len, input bit rs, input bit rdn);
    bit busy, anyDrain, ill;
    int b;
    busy     = (mState[0] == 1) || (mState[1] == 1);
    anyDrain = (mState[0] == 3) || (mState[1] == 3);
    mGrant   = 0;
    if (ab) begin
      mState[0] = 0; mState[1] = 0;
      fullQ.delete();
      mErr = 0;
    end else begin
      ill = (ws && busy) || (wd && !busy) || (rs && !mAvail) || (rdn && !anyDrain);
      if (rdn && anyDrain) begin
        for (int k = 0; k < 2; k++) if (mState[k] == 3) mState[k] = 0;
      end
      if (rs && mAvail) begin
        b = fullQ.pop_front();
        mState[b] = 3;
      end
      if (ws && !busy) begin
        if (mState[0] == 0 && mState[1] == 0) b = 1 - mLastWr;
        else if (mState[0] == 0)              b = 0;
        else if (mState[1] == 0)              b = 1;
        else begin
          b = fullQ.pop_front();
          if (mDrop < 255) mDrop++;
        end
        mState[b] = 1; mLastWr = b; mWrBank = b; mGrant = 1;
      end
      if (wd && busy) begin
        b = (mState[0] == 1) ? 0 : 1;
        if (len == '0) mState[b] = 0;
        else begin
          mState[b] = 2;
          mLen[b]   = len;
          fullQ.push_back(b);
        end
      end
      if (ill) mErr = 1;
    end
    mBusy  = (mState[0] == 1) || (mState[1] == 1);
    mAvail = (mState[0] != 3) && (mState[1] != 3) && (fullQ.size() > 0);
    if (mAvail) begin
      mRdBank = fullQ[0];
      mRdLen  = mLen[mRdBank];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ctx);
    logic [3:0] bs;
    bs = {2'(mState[1]), 2'(mState[0])};
    checkOutput({ctx, ".wr_grant"},   32'(bus.wr_grant),   32'(mGrant));
    checkOutput({ctx, ".wr_bank"},    32'(bus.wr_bank),    32'(mWrBank));
    checkOutput({ctx, ".wr_busy"},    32'(bus.wr_busy),    32'(mBusy));
    checkOutput({ctx, ".rd_avail"},   32'(bus.rd_avail),   32'(mAvail));
    checkOutput({ctx, ".rd_bank"},    32'(bus.rd_bank),    32'(mRdBank));
    checkOutput({ctx, ".rd_len"},     32'(bus.rd_len),     32'(mRdLen));
    checkOutput({ctx, ".drop_cnt"},   32'(bus.drop_cnt),   32'(mDrop));
    checkOutput({ctx, ".bank_state"}, 32'(bus.bank_state), 32'(bs));
    checkOutput({ctx, ".proto_err"},  32'(bus.proto_err),  32'(mErr));
  endtask

  task automatic applyStimulus(input string ctx, input bit ab, input bit ws, input bit wd,
                               input logic [AW-1:0] len, input bit rs, input bit rdn);
    bus.abort    = ab;
    bus.wr_start = ws;
    bus.wr_done  = wd;
    bus.wr_len   = len;
    bus.rd_start = rs;
    bus.rd_done  = rdn;
    modelStep(ab, ws, wd, len, rs, rdn);
    @(posedge clk);
    #1;
    bus.abort    = 1'b0;
    bus.wr_start = 1'b0;
    bus.wr_done  = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_done  = 1'b0;
    checkAll(ctx);
  endtask

  initial begin
    bus.abort = 1'b0; bus.wr_start = 1'b0; bus.wr_done = 1'b0;
    bus.wr_len = '0; bus.rd_start = 1'b0; bus.rd_done = 1'b0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    // First frame lands in bank 0 and becomes readable.
    applyStimulus("t1.start", 0, 1, 0, '0, 0, 0);
    checkOutput("t1.grant", 32'(bus.wr_grant), 32'd1);
    checkOutput("t1.bank",  32'(bus.wr_bank),  32'd0);
    applyStimulus("t1.done", 0, 0, 1, 20'h4B000, 0, 0);
    checkOutput("t1.avail",  32'(bus.rd_avail), 32'd1);
    checkOutput("t1.rdbank", 32'(bus.rd_bank),  32'd0);
    checkOutput("t1.rdlen",  32'(bus.rd_len),   32'h4B000);

    // Both banks full, third frame overwrites the oldest; reader gets bank 1.
    applyStimulus("t2.start2", 0, 1, 0, '0, 0, 0);
    applyStimulus("t2.done2",  0, 0, 1, 20'h00100, 0, 0);
    checkOutput("t2.bothfull", 32'(bus.bank_state), 32'hA);
    applyStimulus("t2.start3", 0, 1, 0, '0, 0, 0);
    checkOutput("t2.bank3", 32'(bus.wr_bank),  32'd0);
    checkOutput("t2.drop",  32'(bus.drop_cnt), 32'd1);
    applyStimulus("t2.done3",  0, 0, 1, 20'h00200, 0, 0);
    checkOutput("t2.rdbank", 32'(bus.rd_bank), 32'd1);
    checkOutput("t2.rdlen",  32'(bus.rd_len),  32'h00100);
    applyStimulus("t2.rdstart", 0, 0, 0, '0, 1, 0);
    checkOutput("t2.draining", 32'(bus.bank_state), 32'hE);

    // Bank 0 draining, bank 1 full: grant in the rd_done cycle reuses bank 0.
    applyStimulus("t3.rddone",  0, 0, 0, '0, 0, 1);
    applyStimulus("t3.rdstart", 0, 0, 0, '0, 1, 0);
    applyStimulus("t3.start",   0, 1, 0, '0, 0, 0);
    applyStimulus("t3.done",    0, 0, 1, 20'h00300, 0, 0);
    checkOutput("t3.setup", 32'(bus.bank_state), 32'hB);
    applyStimulus("t3.start_rddone", 0, 1, 0, '0, 0, 1);
    checkOutput("t3.bank", 32'(bus.wr_bank),  32'd0);
    checkOutput("t3.drop", 32'(bus.drop_cnt), 32'd1);
    applyStimulus("t3.done2", 0, 0, 1, 20'h00400, 0, 0);

    // Zero-length frame frees its bank without counting a drop.
    applyStimulus("t4.abort", 1, 0, 0, '0, 0, 0);
    applyStimulus("t4.start", 0, 1, 0, '0, 0, 0);
    applyStimulus("t4.done0", 0, 0, 1, '0, 0, 0);
    checkOutput("t4.avail", 32'(bus.rd_avail),   32'd0);
    checkOutput("t4.state", 32'(bus.bank_state), 32'd0);
    checkOutput("t4.drop",  32'(bus.drop_cnt),   32'd1);

    // Illegal handshakes set the sticky error; abort clears it.
    applyStimulus("t5.badrd", 0, 0, 0, '0, 1, 0);
    checkOutput("t5.err1", 32'(bus.proto_err), 32'd1);
    applyStimulus("t5.start", 0, 1, 0, '0, 0, 0);
    applyStimulus("t5.start_busy", 0, 1, 0, '0, 0, 0);
    checkOutput("t5.err2", 32'(bus.proto_err), 32'd1);
    applyStimulus("t5.abort", 1, 0, 0, '0, 0, 0);
    checkOutput("t5.errclr", 32'(bus.proto_err),  32'd0);
    checkOutput("t5.state0", 32'(bus.bank_state), 32'd0);

    // Sustained overwrites saturate the drop counter.
    applyStimulus("t6.s1", 0, 1, 0, '0, 0, 0);
    applyStimulus("t6.d1", 0, 0, 1, 20'h00010, 0, 0);
    applyStimulus("t6.s2", 0, 1, 0, '0, 0, 0);
    applyStimulus("t6.d2", 0, 0, 1, 20'h00020, 0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus("t6.ovs", 0, 1, 0, '0, 0, 0);
      applyStimulus("t6.ovd", 0, 0, 1, AW'($urandom_range(1, 20'hFFFFF)), 0, 0);
    end
    checkOutput("t6.sat", 32'(bus.drop_cnt), 32'd255);

    // Random traffic, including illegal and coincident handshakes.
    for (int i = 0; i < 1500; i++) begin
      bit ab, ws, wd, rs, rdn;
      logic [AW-1:0] len;
      ab  = ($urandom_range(0, 49) == 0);
      ws  = ($urandom_range(0, 3) == 0);
      wd  = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      rdn = ($urandom_range(0, 4) == 0);
      len = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 20'hFFFFF));
      applyStimulus("rnd", ab, ws, wd, len, rs, rdn);
    end

    // Reset mid-fill clears every output without a clock edge.
    applyStimulus("t8.abort", 1, 0, 0, '0, 0, 0);
    applyStimulus("t8.start", 0, 1, 0, '0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("t8.rst");
    checkOutput("t8.busy", 32'(bus.wr_busy),  32'd0);
    checkOutput("t8.drop", 32'(bus.drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("t8.restart", 0, 1, 0, '0, 0, 0);
    checkOutput("t8.bank", 32'(bus.wr_bank), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
